iob_split_to: RTL and testbench

- Parametrised successor of the native-bus splitter used on the CPU instruction, data and peripheral paths.
- Routes one master request to one of N_SLAVES slaves, selected by a configurable address field.
- Adds decode-error and timeout error responses, with sticky status and a saturating error counter, so a bad or hung access no longer stalls the CPU.
- Sits between the CPU bus and the peripheral/memory slaves.

---
 rtl/iob_split_to.sv | 95 +++++++++
 tb/tb_iob_split_to.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/iob_split_to.sv
// iob_split_to: routes one native-bus master to N_SLAVES slaves by address field, with decode-error and timeout responses.
module iob_split_to #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int N_SLAVES = 4,
    parameter int SEL_W = 2,
    parameter int P_SLAVES = ADDR_W - 2,
    parameter int TIMEOUT = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF),
    localparam int REQ_W = 1 + ADDR_W + DATA_W + DATA_W / 8,
    localparam int RESP_W = DATA_W + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REQ_W-1:0]           m_req,
    output logic [RESP_W-1:0]          m_resp,
    output logic [N_SLAVES*REQ_W-1:0]  s_req,
    input  logic [N_SLAVES*RESP_W-1:0] s_resp,
    input  logic                       err_clr,
    output logic                       err_decode,
    output logic                       err_timeout,
    output logic [7:0]                 err_cnt
);
    localparam int CNT_W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;
    state_t state, state_nx;
    logic [SEL_W-1:0] sel, sel_q, sel_cur;
    logic [CNT_W-1:0] cnt;
    logic [RESP_W-1:0] hit_resp;
    logic [N_SLAVES-1:0] s_valid;
    logic m_valid, sel_ok, route, to_hit, set_dec, set_to;
    assign m_valid = m_req[REQ_W-1];
    assign sel = m_req[DATA_W + DATA_W / 8 + P_SLAVES -: SEL_W];
    assign sel_ok = {1'b0, sel} < (SEL_W + 1)'(N_SLAVES);
    assign to_hit = TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT);
    assign sel_cur = state == IDLE ? sel : sel_q;
    assign route = m_valid && (state == IDLE ? sel_ok : state == WAIT);
    always_comb begin
        hit_resp = '0;
        s_valid = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) hit_resp = s_resp[i*RESP_W +: RESP_W];
            s_valid[i] = route && sel_cur == SEL_W'(i);
        end
    end
    for (genvar i = 0; i < N_SLAVES; i++) begin : g_slv
        assign s_req[i*REQ_W +: REQ_W] = {s_valid[i], m_req[REQ_W-2:0]};
    end
    always_comb begin
        state_nx = state;
        m_resp = '0;
        set_dec = 1'b0;
        set_to = 1'b0;
        case (state)
            IDLE: begin
                state_nx = m_valid ? (sel_ok ? WAIT : ERR) : IDLE;
                set_dec = m_valid && !sel_ok;
            end
            WAIT: begin
                m_resp = hit_resp;
                set_to = !hit_resp[0] && to_hit;
                state_nx = hit_resp[0] ? IDLE : set_to ? ERR : WAIT;
            end
            ERR: begin
                m_resp = {ERR_DATA, 1'b1};
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel_q <= '0;
            cnt <= '0;
            err_decode <= 1'b0;
            err_timeout <= 1'b0;
            err_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && m_valid && sel_ok) begin
                sel_q <= sel;
                cnt <= CNT_W'(1);
            end else if (state == WAIT) begin
                cnt <= cnt + 1'b1;
            end
            err_decode <= set_dec || (err_decode && !err_clr);
            err_timeout <= set_to || (err_timeout && !err_clr);
            if (set_dec || set_to)
                err_cnt <= err_clr ? 8'd1 : err_cnt + {7'd0, err_cnt != 8'hFF};
            else if (err_clr)
                err_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_iob_split_to.sv
// tb_iob_split_to: randomized scoreboard bench for iob_split_to against a transaction-level model.
module tb_iob_split_to;
    localparam int NS = 3;
    localparam int TO = 4;
    localparam int RQ = 69;
    localparam int RS = 33;
    typedef struct {
        logic [31:0] rd;
        int lat;
        int cnt;
        bit dec;
        bit to;
        int start;
    } exp_t;
    logic clk = 0;
    logic rst = 1;
    logic [RQ-1:0] m_req;
    logic [RS-1:0] m_resp;
    logic [NS*RQ-1:0] s_req;
    logic [NS*RS-1:0] s_resp;
    logic err_clr, err_decode, err_timeout;
    logic [7:0] err_cnt;
    logic [RQ-1:0] m_req_n;
    logic [RS-1:0] m_resp_n;
    logic [4*RQ-1:0] s_req_n;
    logic [4*RS-1:0] s_resp_n;
    logic err_decode_n, err_timeout_n;
    logic [7:0] err_cnt_n;
    exp_t q[$];
    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int mcnt = 0;
    bit mdec = 0;
    bit mto = 0;

    iob_split_to #(.N_SLAVES(NS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_resp(m_resp), .s_req(s_req), .s_resp(s_resp),
        .err_clr(err_clr), .err_decode(err_decode), .err_timeout(err_timeout), .err_cnt(err_cnt)
    );
    iob_split_to #(.N_SLAVES(4), .TIMEOUT(0)) dut_nt (
        .clk(clk), .rst(rst), .m_req(m_req_n), .m_resp(m_resp_n), .s_req(s_req_n), .s_resp(s_resp_n),
        .err_clr(1'b0), .err_decode(err_decode_n), .err_timeout(err_timeout_n), .err_cnt(err_cnt_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [NS-1:0] svalid();
        logic [NS-1:0] v;
        for (int i = 0; i < NS; i++) v[i] = s_req[i*RQ + RQ - 1];
        return v;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected outcome follows directly from the routing rules: bad select,
    // slave answering within the window, or slave too slow / silent (d==0).
    task automatic do_txn(input int sel, input int d, input logic [31:0] data, input bit clr);
        exp_t e;
        logic [31:0] addr;
        bit done, tmo, bad;
        int vis;
        done = 0;
        addr = $urandom;
        addr[30:29] = 2'(sel);
        bad = sel >= NS;
        tmo = !bad && (d == 0 || d > TO);
        if (clr) begin
            mcnt = 0;
            mdec = 0;
            mto = 0;
        end
        if ((bad || tmo) && mcnt < 255) mcnt++;
        if (bad) mdec = 1;
        if (tmo) mto = 1;
        e.rd = (bad || tmo) ? 32'hDEADBEEF : data;
        e.lat = bad ? 1 : tmo ? TO + 1 : d;
        vis = bad ? -1 : tmo ? TO : d;
        e.cnt = mcnt;
        e.dec = mdec;
        e.to = mto;
        e.start = cyc;
        q.push_back(e);
        m_req = {1'b1, addr, 32'($urandom), 4'($urandom)};
        err_clr = clr;
        for (int j = 0; j < 20 && !done; j++) begin
            for (int i = 0; i < NS; i++)
                s_resp[i*RS +: RS] = (i == sel && d != 0 && j == d) ? {data, 1'b1} : {32'($urandom), 1'b0};
            @(negedge clk);
            check("s_valid", svalid(), j <= vis ? NS'(1 << sel) : '0);
            check("broadcast", s_req[(j % NS)*RQ +: RQ-1], m_req[RQ-2:0]);
            done = m_resp[0];
            @(posedge clk);
            #1;
            err_clr = 0;
        end
        if (!done) check("txn_done", 0, 1);
        m_req = '0;
        s_resp = '0;
    endtask

    always @(negedge clk) begin
        if (!rst && m_resp[0]) begin
            if (q.size() == 0) begin
                check("unexpected_ready", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rdata", m_resp[RS-1:1], e.rd);
                check("latency", cyc - e.start, e.lat);
                check("err_cnt", err_cnt, e.cnt);
                check("err_decode", err_decode, e.dec);
                check("err_timeout", err_timeout, e.to);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] addr;
        int nr;
        m_req = '0;
        s_resp = '0;
        err_clr = 0;
        m_req_n = '0;
        s_resp_n = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m_resp", m_resp, 0);
        check("rst_s_valid", svalid(), 0);
        check("rst_err_cnt", err_cnt, 0);
        @(posedge clk);
        #1;
        rst = 0;
        do_txn(2, 3, 32'h12345678, 0);
        idle(1);
        do_txn(3, 2, $urandom, 0);
        do_txn(1, 0, $urandom, 0);
        idle(1);
        s_resp[RS +: RS] = {32'h55AA55AA, 1'b1};
        @(negedge clk);
        check("late_ready_dropped", m_resp, 0);
        @(posedge clk);
        #1;
        s_resp = '0;
        do_txn(1, 4, 32'hCAFEF00D, 0);
        addr = $urandom;
        addr[30:29] = 2'd0;
        m_req = {1'b1, addr, 32'h0, 4'hF};
        idle(2);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        m_req = '0;
        s_resp[0 +: RS] = {32'h11111111, 1'b1};
        mcnt = 0;
        mdec = 0;
        mto = 0;
        @(negedge clk);
        check("midrst_m_resp", m_resp, 0);
        check("midrst_s_valid", svalid(), 0);
        check("midrst_flags", {err_decode, err_timeout}, 0);
        check("midrst_err_cnt", err_cnt, 0);
        @(posedge clk);
        #1;
        s_resp = '0;
        do_txn(0, 2, 32'h0BADF00D, 0);
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                err_clr = 1;
                mcnt = 0;
                mdec = 0;
                mto = 0;
                idle(1);
                err_clr = 0;
            end
            do_txn($urandom_range(0, 3), $urandom_range(0, 6), $urandom, $urandom_range(0, 7) == 0);
            idle($urandom_range(0, 2));
        end
        repeat (300) do_txn(3, 1, 32'h0, 0);
        check("err_cnt_saturated", err_cnt, 255);
        do_txn(3, 1, 32'h0, 1);
        @(negedge clk);
        check("clr_vs_set_cnt", err_cnt, 1);
        check("clr_vs_set_dec", err_decode, 1);
        addr = $urandom;
        addr[30:29] = 2'd1;
        m_req_n = {1'b1, addr, 32'h0, 4'h0};
        nr = 0;
        repeat (300) begin
            @(negedge clk);
            nr += int'(m_resp_n[0]);
        end
        check("no_timeout_ready", nr, 0);
        check("no_timeout_valid", s_req_n[RQ + RQ - 1], 1);
        check("no_timeout_err_cnt", err_cnt_n, 0);
        check("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
